pad_bank_ctrl: RTL

Parametrised controller for a bank of `NCH` bidirectional pads built from PADBID cells, driving each cell's `I` and `OEN` pins and receiving from its `C` pin. Each channel has its own direction state machine with break-before-make turnaround, so a pad is never driven during a direction change. Each channel also has a 2-flop input synchroniser and a glitch filter with edge pulses. This is the successor to the hand-instantiated PADBID bank: channel count, turnaround length and filter length are parameters, and direction is runtime-controlled.

---
 rtl/pad_bank_if.sv | 9 +
 rtl/pad_bank_ctrl.sv | 71 +++++++
 2 files changed

// File: rtl/pad_bank_if.sv
// pad_bank_if: per-channel direction, data and pad signals for pad_bank_ctrl
interface pad_bank_if #(parameter int NCH = 5);
  logic [NCH-1:0] dir_req, dout, pad_c;
  logic [NCH-1:0] pad_i, pad_oen, dir_ack, busy, din, din_rise, din_fall;
  modport master(output dir_req, dout, pad_c,
                 input pad_i, pad_oen, dir_ack, busy, din, din_rise, din_fall);
  modport slave(input dir_req, dout, pad_c,
                output pad_i, pad_oen, dir_ack, busy, din, din_rise, din_fall);
endinterface

// File: rtl/pad_bank_ctrl.sv
// pad_bank_ctrl: per-channel bidirectional pad control with break-before-make turnaround
// and a synchronised, glitch-filtered receive path with edge pulses.
module pad_bank_ctrl #(
  parameter int NCH      = 5,
  parameter int TURN_CYC = 2,
  parameter int FILT_LEN = 4
) (
  input logic      clk,
  input logic      rst,
  pad_bank_if.slave bus
);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  typedef enum logic [1:0] {IN, TURN_OUT, OUT, TURN_IN} st_t;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    st_t st_q, st_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic sync1_q, sync2_q, din_q, din_d, pad_i_q, pad_i_d;
    logic rise_q, rise_d, fall_q, fall_d, tdone, dev, hit;
    always_comb begin
      tdone = tcnt_q == TW'(TURN_CYC - 1);
      st_d = st_q;
      case (st_q)
        IN:       st_d = bus.dir_req[g] ? TURN_OUT : IN;
        TURN_OUT: st_d = tdone ? OUT : TURN_OUT;
        OUT:      st_d = bus.dir_req[g] ? OUT : TURN_IN;
        default:  st_d = tdone ? IN : TURN_IN;
      endcase
      tcnt_d = (st_q == IN || st_q == OUT || tdone) ? '0 : tcnt_q + 1'b1;
      pad_i_d = st_d == OUT && bus.dout[g];
      dev = st_q == IN && sync2_q != din_q;
      hit = dev && fcnt_q == FW'(FILT_LEN - 1);
      fcnt_d = (dev && !hit) ? fcnt_q + 1'b1 : '0;
      din_d = hit ? sync2_q : din_q;
      rise_d = hit && sync2_q;
      fall_d = hit && !sync2_q;
    end
    // Async reset drops the state to IN at once, so pad_oen releases the pad without a clock.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q    <= IN;
        tcnt_q  <= '0;
        fcnt_q  <= '0;
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        din_q   <= 1'b0;
        pad_i_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        st_q    <= st_d;
        tcnt_q  <= tcnt_d;
        fcnt_q  <= fcnt_d;
        sync1_q <= bus.pad_c[g];
        sync2_q <= sync1_q;
        din_q   <= din_d;
        pad_i_q <= pad_i_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end
    assign bus.pad_i[g]    = pad_i_q;
    assign bus.pad_oen[g]  = st_q != OUT;
    assign bus.dir_ack[g]  = st_q == OUT;
    assign bus.busy[g]     = st_q == TURN_OUT || st_q == TURN_IN;
    assign bus.din[g]      = din_q;
    assign bus.din_rise[g] = rise_q;
    assign bus.din_fall[g] = fall_q;
  end
endmodule
